// File: rtl/mux_arb_pkg.sv
// Shared definitions for the four-channel round-robin arbiter:
// FSM state encoding, channel/select sizing and the round-robin pick.
package mux_arb_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Output slot state: EMPTY means no unconsumed word, FULL means f is valid.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Returns the first requesting channel found when scanning ptr, ptr+1,
    // ptr+2, ptr+3 (mod 4). Scanning from the farthest offset down to the
    // nearest lets the nearest hit overwrite the result, so the closest
    // requester to ptr wins. With req == 0 the result is ptr and unused.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                 input logic [SEL_W-1:0]  ptr);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] pick;
        pick = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_4x1_nbits.sv
// Existing N-bit 4:1 datapath multiplexer; sel picks one of w0..w3.
module mux_4x1_nbits #(
    parameter int N = 3
) (
    input  logic [N-1:0] w0,
    input  logic [N-1:0] w1,
    input  logic [N-1:0] w2,
    input  logic [N-1:0] w3,
    input  logic [1:0]   sel,
    output logic [N-1:0] f
);

    // Pure combinational word select.
    always_comb begin
        f = w0;
        case (sel)
            2'd0:    f = w0;
            2'd1:    f = w1;
            2'd2:    f = w2;
            default: f = w3;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters.
// The winner's word is captured into a single registered output slot.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics. A word
// is consumed on any rising edge where out_valid=1 and out_ready=1; while
// out_valid=1 and out_ready=0 the slot (f, sel, out_valid) holds. On the
// producer side gnt[i] is the combinational acknowledge: channel i must hold
// req[i] and w<i> until it sees gnt[i]=1, and the word is taken at that edge.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   req,
    input  logic [N-1:0]        w0,
    input  logic [N-1:0]        w1,
    input  logic [N-1:0]        w2,
    input  logic [N-1:0]        w3,
    input  logic                out_ready,
    output logic [NUM_CH-1:0]   gnt,
    output logic [SEL_W-1:0]    sel,
    output logic [N-1:0]        f,
    output logic                out_valid,
    output logic                dbg_state_o,
    output logic [SEL_W-1:0]    dbg_ptr_o
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N-1:0]       f_q, f_d;

    logic               can_load;
    logic               grant_en;
    logic [SEL_W-1:0]   winner;
    logic [N-1:0]       mux_f;

    // The winner index steers the shared datapath mux directly.
    mux_4x1_nbits #(.N(N)) u_mux (
        .w0  (w0),
        .w1  (w1),
        .w2  (w2),
        .w3  (w3),
        .sel (winner),
        .f   (mux_f)
    );

    // Arbitration: load when the slot is empty or is being drained this cycle.
    // Reset suppresses the grant so no requester believes its word was taken.
    always_comb begin
        can_load = (state_q == EMPTY) || (state_q == FULL && out_ready);
        winner   = rr_pick(req, ptr_q);
        grant_en = can_load && (req != '0) && !reset;
        gnt      = '0;
        if (grant_en) begin
            gnt[winner] = 1'b1;
        end
    end

    // Next-state for the slot FSM, output word, select and round-robin pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        f_d     = f_q;
        if (grant_en) begin
            f_d     = mux_f;
            sel_d   = winner;
            state_d = FULL;
            ptr_d   = winner + 2'd1;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            sel_q   <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            f_q     <= f_d;
        end
    end

    assign out_valid   = (state_q == FULL);
    assign f           = f_q;
    assign sel         = sel_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with hand-computed expectations.
module tb_mux4_rr_arbiter;

    localparam int N = 3;

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [N-1:0] w0, w1, w2, w3;
    logic         out_ready;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [N-1:0] f;
    logic         out_valid;
    logic         dbg_state;
    logic [1:0]   dbg_ptr;

    int tests_run;
    int tests_failed;

    mux4_rr_arbiter #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .w0          (w0),
        .w1          (w1),
        .w2          (w2),
        .w3          (w3),
        .out_ready   (out_ready),
        .gnt         (gnt),
        .sel         (sel),
        .f           (f),
        .out_valid   (out_valid),
        .dbg_state_o (dbg_state),
        .dbg_ptr_o   (dbg_ptr)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational gnt settle after an input change.
    task automatic settle();
        #1;
    endtask

    logic [3:0]   exp_gnt [5];
    logic [N-1:0] exp_f   [5];
    logic [1:0]   exp_sel [5];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_f   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset with all channels requesting.
        reset = 1'b1; req = 4'b1111; out_ready = 1'b1;
        w0 = 3'd1; w1 = 3'd2; w2 = 3'd3; w3 = 3'd4;
        settle();
        check("rst_gnt", 32'(gnt), 32'h0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_gnt_hold", 32'(gnt), 32'h0);
            check("rst_valid", 32'(out_valid), 32'h0);
            check("rst_f", 32'(f), 32'h0);
            check("rst_sel", 32'(sel), 32'h0);
        end
        check("rst_ptr", 32'(dbg_ptr), 32'h0);

        // Full contention: rotation 0,1,2,3 then wrap to 0.
        reset = 1'b0;
        settle();
        for (int i = 0; i < 5; i++) begin
            check("fc_gnt", 32'(gnt), 32'(exp_gnt[i]));
            tick();
            check("fc_f", 32'(f), 32'(exp_f[i]));
            check("fc_sel", 32'(sel), 32'(exp_sel[i]));
            check("fc_valid", 32'(out_valid), 32'h1);
        end
        check("fc_ptr", 32'(dbg_ptr), 32'h1);

        // Load f=5 from channel 1 (ptr=1).
        req = 4'b0010; w1 = 3'd5;
        settle();
        check("ld5_gnt", 32'(gnt), 32'h2);
        tick();
        check("ld5_f", 32'(f), 32'h5);

        // Stall three cycles with channel 2 requesting.
        out_ready = 1'b0; req = 4'b0100; w2 = 3'd6;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("stall_gnt", 32'(gnt), 32'h0);
            tick();
            check("stall_f", 32'(f), 32'h5);
            check("stall_valid", 32'(out_valid), 32'h1);
            check("stall_sel", 32'(sel), 32'h1);
        end
        out_ready = 1'b1;
        settle();
        check("unstall_gnt", 32'(gnt), 32'h4);
        tick();
        check("unstall_f", 32'(f), 32'h6);
        check("unstall_sel", 32'(sel), 32'h2);
        check("unstall_ptr", 32'(dbg_ptr), 32'h3);

        // Move ptr to 2 via channel 1 (scan 3,0,1).
        req = 4'b0010;
        settle();
        check("mv_gnt", 32'(gnt), 32'h2);
        tick();
        check("mv_ptr", 32'(dbg_ptr), 32'h2);

        // Skip: ptr=2, req=0011 -> channel 0 after wrap, then channel 1.
        req = 4'b0011; w0 = 3'd7;
        settle();
        check("skip_gnt0", 32'(gnt), 32'h1);
        tick();
        check("skip_f0", 32'(f), 32'h7);
        check("skip_ptr1", 32'(dbg_ptr), 32'h1);
        settle();
        check("skip_gnt1", 32'(gnt), 32'h2);
        tick();
        check("skip_f1", 32'(f), 32'h5);
        check("skip_ptr2", 32'(dbg_ptr), 32'h2);

        // Drain: no requests, consumer ready.
        req = 4'b0000;
        settle();
        check("drain_gnt", 32'(gnt), 32'h0);
        tick();
        check("drain_valid", 32'(out_valid), 32'h0);
        check("drain_state", 32'(dbg_state), 32'h0);
        check("drain_ptr", 32'(dbg_ptr), 32'h2);
        tick();
        check("empty_valid", 32'(out_valid), 32'h0);
        check("empty_f_hold", 32'(f), 32'h5);
        check("empty_sel_hold", 32'(sel), 32'h1);

        // Single requester on channel 3 is granted every opportunity.
        req = 4'b1000; w3 = 3'd4;
        for (int c = 0; c < 2; c++) begin
            settle();
            check("single_gnt", 32'(gnt), 32'h8);
            tick();
            check("single_f", 32'(f), 32'h4);
            check("single_ptr", 32'(dbg_ptr), 32'h0);
        end

        // Reset coinciding with a grant opportunity while FULL.
        req = 4'b0100; w2 = 3'd6; reset = 1'b1;
        settle();
        check("rstmid_gnt", 32'(gnt), 32'h0);
        tick();
        check("rstmid_valid", 32'(out_valid), 32'h0);
        check("rstmid_f", 32'(f), 32'h0);
        check("rstmid_ptr", 32'(dbg_ptr), 32'h0);
        reset = 1'b0; req = 4'b1111;
        settle();
        check("post_rst_gnt", 32'(gnt), 32'h1);
        tick();
        check("post_rst_f", 32'(f), 32'h7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
